// File: rtl/mavg_pkg.sv
// Shared widths, the sample type and the saturation helper for the moving-average datapath.
package mavg_pkg;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 8;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Clamp a signed value into the signed range of an out_w-bit operand.
  function automatic int sat_signed(input int sum, input int out_w);
    int max_v;
    int min_v;
    max_v = (1 << (out_w - 1)) - 1;
    min_v = -(1 << (out_w - 1));
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/mavg_ring_buf.sv
// Sample ring buffer: synchronous write, asynchronous read of the slot about to be overwritten.
module mavg_ring_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;

  // Write pointer: cleared on reset/flush, advances per write and wraps naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ptr <= '0;
    end else if (we) begin
      r_ptr <= r_ptr + PTR_W'(1);
    end
  end

  // Storage has no reset; the fill count in the parent decides whether a slot is meaningful.
  always_ff @(posedge clk) begin
    if (we && !clr) begin
      r_mem[r_ptr] <= wdata;
    end
  end

  assign rd_data = r_mem[r_ptr];

endmodule

// File: rtl/mavg_window_acc.sv
// Sliding-window accumulator feeding int_div: running window sum, fill count and saturated dividend.
//
// Handshake (both sides): a transfer happens on a rising clk edge where valid && ready.
// Upstream may not assume acceptance otherwise; out_valid holds with stable data until out_ready.
// in_ready = !out_valid || out_ready (forced 0 during rst/flush), so a single output register
// gives full throughput and there is no combinational path from in_data to any output.
module mavg_window_acc #(
  parameter int DATA_W = mavg_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int SUM_W  = DATA_W + $clog2(DEPTH),
  parameter int OUT_W  = mavg_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum_o,
  output logic [OUT_W-1:0]  dividend_o,
  output logic [OUT_W-1:0]  divisor_o,
  output logic              sat_o
);

  import mavg_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic                    w_clr;
  logic                    w_accept;
  logic                    w_full;
  logic [DATA_W-1:0]       w_rd_data;
  logic signed [SUM_W-1:0] w_new;
  logic signed [SUM_W-1:0] w_old;
  logic signed [SUM_W-1:0] w_sum_next;
  logic [CNT_W-1:0]        w_count_next;
  int                      w_sum_int;
  int                      w_clamped;

  logic signed [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0]        r_count;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_dividend;
  logic                    r_sat;

  assign w_clr    = rst | flush;
  assign in_ready = !w_clr && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_full   = (r_count == FULL);

  mavg_ring_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk     (clk),
    .clr     (w_clr),
    .we      (w_accept),
    .wdata   (in_data),
    .rd_data (w_rd_data)
  );

  // Next window sum: add the new sample, retire the oldest once the window is full.
  always_comb begin
    w_new        = SUM_W'($signed(in_data));
    w_old        = '0;
    if (w_full) begin
      w_old = SUM_W'($signed(w_rd_data));
    end
    w_sum_next   = r_sum + w_new - w_old;
    w_count_next = w_full ? r_count : r_count + CNT_W'(1);
    w_sum_int    = int'(w_sum_next);
    w_clamped    = sat_signed(w_sum_int, OUT_W);
  end

  // Running state doubles as the output register: it only changes on an accepted sample.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_dividend  <= '0;
      r_sat       <= 1'b0;
    end else if (w_accept) begin
      r_sum       <= w_sum_next;
      r_count     <= w_count_next;
      r_out_valid <= 1'b1;
      r_dividend  <= OUT_W'(w_clamped);
      r_sat       <= (w_clamped != w_sum_int);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign sum_o      = r_sum;
  assign dividend_o = r_dividend;
  assign divisor_o  = OUT_W'(r_count);
  assign sat_o      = r_sat;

endmodule

// File: tb/tb_mavg_window_acc.sv
// Bench for mavg_window_acc: directed window scenarios plus a random stream against a queue model.
module tb_mavg_window_acc;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] sum_o;
  logic [7:0]  dividend_o;
  logic [7:0]  divisor_o;
  logic        sat_o;

  int n_vec;
  int n_err;
  bit started;

  // Reference model state
  int win[$];
  bit m_valid;
  bit m_rdy;
  int m_sum;
  int m_div;
  int m_dvd;
  bit m_sat;

  mavg_window_acc u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_o      (sum_o),
    .dividend_o (dividend_o),
    .divisor_o  (divisor_o),
    .sat_o      (sat_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the window is simply the last DEPTH accepted samples; sum is their total.
  always @(posedge clk) begin
    m_rdy = !rst && !flush && (!m_valid || out_ready);
    if (rst || flush) begin
      win.delete();
      m_valid = 1'b0;
      m_sum = 0;
      m_div = 0;
      m_dvd = 0;
      m_sat = 1'b0;
    end else if (in_valid && m_rdy) begin
      win.push_back(int'($signed(in_data)));
      if (win.size() > DEPTH) void'(win.pop_front());
      m_sum = 0;
      foreach (win[k]) m_sum += win[k];
      m_div = win.size();
      if (m_sum > 127) begin
        m_dvd = 127; m_sat = 1'b1;
      end else if (m_sum < -128) begin
        m_dvd = -128; m_sat = 1'b1;
      end else begin
        m_dvd = m_sum; m_sat = 1'b0;
      end
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", int'(in_ready), int'(!rst && !flush && (!m_valid || out_ready)));
      check("out_valid", int'(out_valid), int'(m_valid));
      check("sum_o", int'($signed(sum_o)), m_sum);
      check("dividend_o", int'($signed(dividend_o)), m_dvd);
      check("divisor_o", int'(divisor_o), m_div);
      check("sat_o", int'(sat_o), int'(m_sat));
      if (out_valid) check("divisor_nonzero", int'(divisor_o != 8'd0), 1);
    end
  end

  // Driver tasks
  task automatic push(input int d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_chk(input int d, input int es, input int ed, input int edv, input int esat);
    push(d);
    @(negedge clk);
    check("lit_sum", int'($signed(sum_o)), es);
    check("lit_model_sum", m_sum, es);
    check("lit_divisor", int'(divisor_o), ed);
    check("lit_dividend", int'($signed(dividend_o)), edv);
    check("lit_sat", int'(sat_o), esat);
    check("lit_out_valid", int'(out_valid), 1);
  endtask

  task automatic do_flush();
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // Drop a sample in the same cycle as a clear, then confirm the window restarts.
  task automatic clear_mid_stream(input bit use_rst);
    do_flush();
    for (int i = 1; i <= 5; i++) push(i);
    @(negedge clk);
    check("pre_clear_count", int'(divisor_o), 5);
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clear_out_valid", int'(out_valid), 0);
    check("clear_divisor", int'(divisor_o), 0);
    push_chk(7, 7, 1, 7, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; started = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    m_valid = 1'b0; m_sum = 0; m_div = 0; m_dvd = 0; m_sat = 1'b0;
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_sum", int'(sum_o), 0);
    check("reset_divisor", int'(divisor_o), 0);
    check("reset_out_valid", int'(out_valid), 0);

    // Fill from empty
    do_reset();
    push_chk(10, 10, 1, 10, 0);
    push_chk(20, 30, 2, 30, 0);
    push_chk(30, 60, 3, 60, 0);

    // Wrap-around
    do_flush();
    for (int i = 0; i < 7; i++) push(10);
    push_chk(10, 80, 8, 80, 0);
    push_chk(-50, 20, 8, 20, 0);
    push_chk(0, 10, 8, 10, 0);

    // Saturation and extremes
    do_flush();
    for (int i = 0; i < 7; i++) push(100);
    push_chk(100, 800, 8, 127, 1);
    for (int i = 0; i < 7; i++) push(-128);
    push_chk(-128, -1024, 8, -128, 1);
    for (int i = 0; i < 7; i++) push(127);
    push_chk(127, 1016, 8, 127, 1);

    // Backpressure: a stalled sample is taken exactly once when out_ready returns
    do_flush();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'd11;
    @(posedge clk); #1;
    out_ready = 1'b0; in_data = 8'd22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_sum", int'($signed(sum_o)), 11);
      check("stall_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("resume_sum", int'($signed(sum_o)), 33);
    check("resume_divisor", int'(divisor_o), 2);

    // Mid-stream flush, then reset
    clear_mid_stream(1'b0);
    clear_mid_stream(1'b1);

    // Single negative sample
    do_flush();
    push_chk(-49, -49, 1, -49, 0);

    // Random stream with random backpressure and rare flushes
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
